pipeline_hazard_ctrl: RTL and testbench

- Produces the `stall`, `flush` and `io_stall` controls that every pipeline register stage consumes.
- Tracks in-flight long-latency ALU/FPU results in a per-register countdown scoreboard and detects RAW hazards at dispatch.
- Detects the structural hazard on the non-pipelined long ALU and mispredicted branches.
- Runs a small FSM that holds the pipeline while the UART input/output handshake is pending.

---
 rtl/pipeline_hazard_ctrl_if.sv | 56 +++++
 rtl/pipeline_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundles the dispatch-stage, exec-stage, cache and UART signals seen by the
// hazard controller, together with the pipeline controls it returns.
//
// Handshake semantics:
//   The dispatch instruction is a valid/ready transfer. issue_valid is the
//   valid side. The ready side is ~stall & ~flush & ~io_stall. The
//   instruction is accepted only in a cycle where both sides are high. While
//   it is not accepted, the dispatch stage must hold issue_valid and all
//   instruction fields stable.
//   The UART side is consumed as level signals. rx_valid means a received
//   byte is present. tx_ready means the transmitter can take a byte.
//
// Modports:
//   master - drives the instruction/status inputs, observes the controls
//   slave  - the hazard controller itself
// io_wait is a debug view of the I/O FSM state (1 = WAIT).
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if;
   logic       issue_valid;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic [4:0] rs3;
   logic [2:0] uses_rs;
   logic [2:0] rs_fpu;
   logic [4:0] rd;
   logic       reg_write;
   logic       fpu_reg_write;
   logic       long_alu_en;
   logic       long_fpu_en;
   logic       branch_mispredict;
   logic       cache_busy;
   logic       input_en;
   logic       output_en;
   logic       rx_valid;
   logic       tx_ready;
   logic       stall;
   logic       flush;
   logic       io_stall;
   logic       io_wait;

   modport master (
      output issue_valid, rs1, rs2, rs3, uses_rs, rs_fpu, rd, reg_write,
             fpu_reg_write, long_alu_en, long_fpu_en, branch_mispredict,
             cache_busy, input_en, output_en, rx_valid, tx_ready,
      input  stall, flush, io_stall, io_wait
   );

   modport slave (
      input  issue_valid, rs1, rs2, rs3, uses_rs, rs_fpu, rd, reg_write,
             fpu_reg_write, long_alu_en, long_fpu_en, branch_mispredict,
             cache_busy, input_en, output_en, rx_valid, tx_ready,
      output stall, flush, io_stall, io_wait
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Generates stall / flush / io_stall for every pipeline register stage.
//   - Per-register countdown scoreboards detect RAW hazards on results that
//     are still in flight in the long ALU/FPU. There are 32 integer and
//     32 FP scoreboard entries.
//   - A busy counter detects the structural hazard on the non-pipelined long
//     ALU.
//   - A flush counter stretches a mispredict into FLUSH_CYCLES bubble cycles.
//   - A two-state FSM holds the pipeline while a UART in/out op waits.
// Ports:
//   clk - clock
//   rst - synchronous active-high reset
//   hz  - slave side of pipeline_hazard_ctrl_if (dispatch fields, status
//         inputs, stall/flush/io_stall outputs, io_wait debug state)
// All outputs are combinational from registered state and current inputs.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
   parameter int LONG_ALU_LAT = 4,
   parameter int LONG_FPU_LAT = 6,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   pipeline_hazard_ctrl_if.slave   hz
);

   localparam int MAX_LAT = (LONG_ALU_LAT > LONG_FPU_LAT) ? LONG_ALU_LAT : LONG_FPU_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);
   localparam int FW      = $clog2(FLUSH_CYCLES + 1);

   // The issue cycle is the first latency cycle. A counter therefore holds
   // the number of further cycles a consumer must wait: LAT-1 after issue.
   // For example, a 4-cycle unit stalls a back-to-back reader for 3 cycles.
   localparam logic [CW-1:0] ALU_LOAD   = CW'(LONG_ALU_LAT - 1);
   localparam logic [CW-1:0] FPU_LOAD   = CW'(LONG_FPU_LAT - 1);
   localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

   typedef enum logic {IO_IDLE = 1'b0, IO_WAIT = 1'b1} io_state_t;

   logic [CW-1:0] int_cnt [32];
   logic [CW-1:0] fp_cnt  [32];
   logic [CW-1:0] busy_cnt;
   logic [FW-1:0] flush_cnt;
   io_state_t     io_state;

   logic [4:0] rs_arr [3];
   logic       raw_haz;
   logic       struct_haz;
   logic       mem_haz;
   logic       flush_c;
   logic       io_pending;
   logic       io_stall_c;
   logic       stall_c;
   logic       accept;

   always_comb begin
      rs_arr[0] = hz.rs1;
      rs_arr[1] = hz.rs2;
      rs_arr[2] = hz.rs3;
   end

   // RAW: any read source whose selected file entry is still counting down.
   always_comb begin
      raw_haz = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (hz.issue_valid && hz.uses_rs[i]) begin
            if (hz.rs_fpu[i]) begin
               if (fp_cnt[rs_arr[i]] != '0) raw_haz = 1'b1;
            end else if (rs_arr[i] != 5'd0) begin
               if (int_cnt[rs_arr[i]] != '0) raw_haz = 1'b1;
            end
         end
      end
   end

   assign struct_haz = hz.issue_valid & hz.long_alu_en & (busy_cnt != '0);
   assign mem_haz    = hz.cache_busy;

   // Priority: rst > flush > io_stall > stall.
   assign flush_c    = ~rst & (hz.branch_mispredict | (flush_cnt != '0));
   assign io_pending = hz.issue_valid &
                       ((hz.input_en & ~hz.rx_valid) | (hz.output_en & ~hz.tx_ready));
   // The expression is the same in both FSM states. In IDLE it is the
   // triggering cycle. In WAIT it holds until the UART condition clears.
   assign io_stall_c = ~rst & ~flush_c & io_pending;
   assign stall_c    = ~rst & (raw_haz | struct_haz | mem_haz) & ~flush_c & ~io_stall_c;
   assign accept     = hz.issue_valid & ~stall_c & ~flush_c & ~io_stall_c;

   assign hz.stall    = stall_c;
   assign hz.flush    = flush_c;
   assign hz.io_stall = io_stall_c;
   assign hz.io_wait  = (io_state == IO_WAIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            int_cnt[i] <= '0;
            fp_cnt[i]  <= '0;
         end
         busy_cnt  <= '0;
         flush_cnt <= '0;
         io_state  <= IO_IDLE;
      end else begin
         // Free-running countdown, independent of the pipeline controls.
         for (int i = 0; i < 32; i++) begin
            if (int_cnt[i] != '0) int_cnt[i] <= int_cnt[i] - CW'(1);
            if (fp_cnt[i] != '0)  fp_cnt[i]  <= fp_cnt[i] - CW'(1);
         end
         if (busy_cnt != '0) busy_cnt <= busy_cnt - CW'(1);

         // Loads on accepted issue override the decrement above.
         if (accept && hz.long_alu_en) begin
            busy_cnt <= ALU_LOAD;
            if (hz.reg_write && hz.rd != 5'd0) int_cnt[hz.rd] <= ALU_LOAD;
         end
         if (accept && hz.long_fpu_en) begin
            if (hz.fpu_reg_write)
               fp_cnt[hz.rd] <= FPU_LOAD;
            else if (hz.reg_write && hz.rd != 5'd0)
               int_cnt[hz.rd] <= FPU_LOAD;
         end

         // A mispredict flushes combinationally in its own cycle. The counter
         // covers the remaining bubble cycles. A new mispredict reloads it.
         if (hz.branch_mispredict)
            flush_cnt <= FLUSH_LOAD;
         else if (flush_cnt != '0)
            flush_cnt <= flush_cnt - FW'(1);

         case (io_state)
            IO_IDLE: if (io_pending && !flush_c) io_state <= IO_WAIT;
            IO_WAIT: if (flush_c || !io_pending) io_state <= IO_IDLE;
            default: io_state <= IO_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed testbench for pipeline_hazard_ctrl (default parameters: ALU 4,
// FPU 6, flush 2). Inputs change right after each falling edge. Outputs are
// sampled 1 time unit later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   pipeline_hazard_ctrl_if hz ();

   pipeline_hazard_ctrl dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic clear_inputs();
      hz.issue_valid       = 1'b0;
      hz.rs1               = 5'd0;
      hz.rs2               = 5'd0;
      hz.rs3               = 5'd0;
      hz.uses_rs           = 3'b000;
      hz.rs_fpu            = 3'b000;
      hz.rd                = 5'd0;
      hz.reg_write         = 1'b0;
      hz.fpu_reg_write     = 1'b0;
      hz.long_alu_en       = 1'b0;
      hz.long_fpu_en       = 1'b0;
      hz.branch_mispredict = 1'b0;
      hz.cache_busy        = 1'b0;
      hz.input_en          = 1'b0;
      hz.output_en         = 1'b0;
      hz.rx_valid          = 1'b0;
      hz.tx_ready          = 1'b0;
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         next_cycle();
         clear_inputs();
      end
   endtask

   task automatic long_alu(input logic [4:0] rd);
      clear_inputs();
      hz.issue_valid = 1'b1;
      hz.long_alu_en = 1'b1;
      hz.reg_write   = 1'b1;
      hz.rd          = rd;
   endtask

   task automatic reader(input logic [4:0] rs, input logic fpu);
      clear_inputs();
      hz.issue_valid = 1'b1;
      hz.rs1         = rs;
      hz.uses_rs     = 3'b001;
      hz.rs_fpu      = {2'b00, fpu};
   endtask

   // tests
   task automatic test_reset();
      next_cycle();
      hz.branch_mispredict = 1'b1;
      hz.cache_busy        = 1'b1;
      #1;
      n_checks++;
      if (hz.stall !== 1'b0) begin $display("FAIL rst_stall: got %b want 0", hz.stall); n_fail++; end
      n_checks++;
      if (hz.flush !== 1'b0) begin $display("FAIL rst_flush: got %b want 0", hz.flush); n_fail++; end
      next_cycle();
      rst = 1'b0;
      clear_inputs();
      #1;
      n_checks++;
      if ({hz.stall, hz.flush, hz.io_stall, hz.io_wait} !== 4'b0000) begin
         $display("FAIL post_reset: stall/flush/io_stall/io_wait=%b want 0000",
                  {hz.stall, hz.flush, hz.io_stall, hz.io_wait});
         n_fail++;
      end
   endtask

   task automatic test_raw();
      next_cycle();
      long_alu(5'd5);
      #1;
      n_checks++;
      if (hz.stall !== 1'b0) begin $display("FAIL raw_issue: stall=%b want 0", hz.stall); n_fail++; end
      for (int k = 1; k <= 4; k++) begin
         next_cycle();
         reader(5'd5, 1'b0);
         hz.rd        = 5'd6;
         hz.reg_write = 1'b1;
         #1;
         n_checks++;
         if (hz.stall !== (k < 4)) begin
            $display("FAIL raw_hold cyc%0d: stall=%b want %b", k, hz.stall, (k < 4));
            n_fail++;
         end
      end
      // x0 is never marked busy
      next_cycle();
      long_alu(5'd0);
      #1;
      n_checks++;
      if (hz.stall !== 1'b0) begin $display("FAIL x0_issue: stall=%b want 0", hz.stall); n_fail++; end
      next_cycle();
      reader(5'd0, 1'b0);
      hz.uses_rs = 3'b011;
      #1;
      n_checks++;
      if (hz.stall !== 1'b0) begin $display("FAIL x0_read: stall=%b want 0", hz.stall); n_fail++; end
      idle(4);
   endtask

   task automatic test_struct();
      next_cycle();
      long_alu(5'd7);
      #1;
      n_checks++;
      if (hz.stall !== 1'b0) begin $display("FAIL struct_first: stall=%b want 0", hz.stall); n_fail++; end
      for (int k = 1; k <= 4; k++) begin
         next_cycle();
         long_alu(5'd8);
         #1;
         n_checks++;
         if (hz.stall !== (k < 4)) begin
            $display("FAIL struct_hold cyc%0d: stall=%b want %b", k, hz.stall, (k < 4));
            n_fail++;
         end
      end
      idle(4);
      // pipelined FPU: back-to-back issue never stalls
      for (int k = 0; k < 2; k++) begin
         next_cycle();
         clear_inputs();
         hz.issue_valid   = 1'b1;
         hz.long_fpu_en   = 1'b1;
         hz.fpu_reg_write = 1'b1;
         hz.rd            = 5'(k + 1);
         #1;
         n_checks++;
         if (hz.stall !== 1'b0) begin
            $display("FAIL fpu_b2b op%0d: stall=%b want 0", k, hz.stall);
            n_fail++;
         end
      end
      // f1 still in flight; x1 in the integer file is free
      next_cycle();
      reader(5'd1, 1'b1);
      #1;
      n_checks++;
      if (hz.stall !== 1'b1) begin $display("FAIL fp_raw: stall=%b want 1", hz.stall); n_fail++; end
      next_cycle();
      reader(5'd1, 1'b0);
      #1;
      n_checks++;
      if (hz.stall !== 1'b0) begin $display("FAIL int_vs_fp: stall=%b want 0", hz.stall); n_fail++; end
      idle(6);
   endtask

   task automatic test_flush();
      logic [1:0] exp_sf [4];
      exp_sf[0] = 2'b10;
      exp_sf[1] = 2'b01;
      exp_sf[2] = 2'b01;
      exp_sf[3] = 2'b00;
      next_cycle();
      long_alu(5'd9);
      for (int k = 0; k < 4; k++) begin
         next_cycle();
         reader(5'd9, 1'b0);
         hz.branch_mispredict = (k == 1);
         #1;
         n_checks++;
         if ({hz.stall, hz.flush} !== exp_sf[k]) begin
            $display("FAIL flush_over_raw cyc%0d: stall/flush=%b want %b", k, {hz.stall, hz.flush}, exp_sf[k]);
            n_fail++;
         end
      end
      idle(1);
      // second mispredict in flush cycle 2 extends the flush to 3 cycles
      for (int k = 0; k < 4; k++) begin
         next_cycle();
         clear_inputs();
         hz.branch_mispredict = (k < 2);
         #1;
         n_checks++;
         if (hz.flush !== (k < 3)) begin
            $display("FAIL flush_extend cyc%0d: flush=%b want %b", k, hz.flush, (k < 3));
            n_fail++;
         end
      end
      idle(1);
   endtask

   task automatic test_io();
      for (int k = 0; k <= 5; k++) begin
         next_cycle();
         clear_inputs();
         hz.issue_valid = 1'b1;
         hz.output_en   = 1'b1;
         hz.tx_ready    = (k == 5);
         #1;
         n_checks++;
         if (hz.io_stall !== (k < 5)) begin
            $display("FAIL io_out cyc%0d: io_stall=%b want %b", k, hz.io_stall, (k < 5));
            n_fail++;
         end
      end
      n_checks++;
      if (hz.io_wait !== 1'b1) begin $display("FAIL io_wait_state: io_wait=%b want 1", hz.io_wait); n_fail++; end
      next_cycle();
      clear_inputs();
      #1;
      n_checks++;
      if (hz.io_wait !== 1'b0) begin $display("FAIL io_back_idle: io_wait=%b want 0", hz.io_wait); n_fail++; end
      // input with a byte already present: no wait
      next_cycle();
      clear_inputs();
      hz.issue_valid = 1'b1;
      hz.input_en    = 1'b1;
      hz.rx_valid    = 1'b1;
      #1;
      n_checks++;
      if (hz.io_stall !== 1'b0) begin $display("FAIL io_in_ready: io_stall=%b want 0", hz.io_stall); n_fail++; end
      // flush while in WAIT forces IDLE
      for (int k = 0; k < 5; k++) begin
         logic [2:0] exp_w;
         next_cycle();
         clear_inputs();
         hz.issue_valid       = 1'b1;
         hz.input_en          = 1'b1;
         hz.rx_valid          = (k == 4);
         hz.branch_mispredict = (k == 1);
         #1;
         case (k)
            0:       exp_w = 3'b010;
            1:       exp_w = 3'b101;
            2:       exp_w = 3'b100;
            3:       exp_w = 3'b010;
            default: exp_w = 3'b001;
         endcase
         n_checks++;
         if ({hz.flush, hz.io_stall, hz.io_wait} !== exp_w) begin
            $display("FAIL io_flush cyc%0d: flush/io_stall/io_wait=%b want %b", k, {hz.flush, hz.io_stall, hz.io_wait}, exp_w);
            n_fail++;
         end
      end
      idle(2);
   endtask

   task automatic test_cache();
      next_cycle();
      clear_inputs();
      hz.cache_busy = 1'b1;
      #1;
      n_checks++;
      if ({hz.stall, hz.flush} !== 2'b10) begin
         $display("FAIL cache_stall: stall/flush=%b want 10", {hz.stall, hz.flush});
         n_fail++;
      end
      next_cycle();
      hz.branch_mispredict = 1'b1;
      #1;
      n_checks++;
      if ({hz.stall, hz.flush} !== 2'b01) begin
         $display("FAIL cache_flush: stall/flush=%b want 01", {hz.stall, hz.flush});
         n_fail++;
      end
      idle(2);
   endtask

   task automatic test_reset_mid();
      next_cycle();
      long_alu(5'd10);
      next_cycle();
      clear_inputs();
      hz.issue_valid = 1'b1;
      hz.output_en   = 1'b1;
      #1;
      n_checks++;
      if (hz.io_stall !== 1'b1) begin $display("FAIL mid_io_setup: io_stall=%b want 1", hz.io_stall); n_fail++; end
      next_cycle();
      rst = 1'b1;
      #1;
      n_checks++;
      if ({hz.stall, hz.flush, hz.io_stall} !== 3'b000) begin
         $display("FAIL mid_rst_out: stall/flush/io_stall=%b want 000", {hz.stall, hz.flush, hz.io_stall});
         n_fail++;
      end
      next_cycle();
      rst = 1'b0;
      long_alu(5'd11);
      hz.rs1     = 5'd10;
      hz.uses_rs = 3'b001;
      #1;
      n_checks++;
      if ({hz.stall, hz.flush, hz.io_stall, hz.io_wait} !== 4'b0000) begin
         $display("FAIL mid_rst_after: stall/flush/io_stall/io_wait=%b want 0000",
                  {hz.stall, hz.flush, hz.io_stall, hz.io_wait});
         n_fail++;
      end
      idle(2);
   endtask

   // sequence and final report
   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      clear_inputs();
      test_reset();
      test_raw();
      test_struct();
      test_flush();
      test_io();
      test_cache();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
